// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared definitions for the register-dump read sequencer.
//   - state_e      : sequencer states
//   - DATA_W_DEF   : default register data width
//   - IDX_W_DEF    : default register index width
//   - REG_COUNT    : register count of the default register file
//   - MAX_READ_LAT : largest supported read latency (sizes the wait counter)
package reg_dump_pkg;

    localparam int unsigned DATA_W_DEF   = 16;
    localparam int unsigned IDX_W_DEF    = 4;
    localparam int unsigned REG_COUNT    = 16;
    localparam int unsigned MAX_READ_LAT = 3;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StSendA,
        StSendB,
        StDone
    } state_e;

endpackage

// File: rtl/reg_dump_pair_buf.sv
// reg_dump_pair_buf: holds the A/B read pair captured from the register file
// and presents the half selected by the sequencer state.
//   Clock   in  : system clock
//   Reset   in  : synchronous, active-high reset (clears both halves)
//   Capture in  : load A/B into the hold registers on this edge
//   State   in  : sequencer state; picks which half drives OutData
//   A, B    in  : register file read data
//   OutData out : holdA in StSendA, holdB in StSendB, 0 otherwise
module reg_dump_pair_buf
    import reg_dump_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Capture,
    input  state_e            State,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] OutData
);

    logic [DATA_W-1:0] hold_a_q;
    logic [DATA_W-1:0] hold_b_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            hold_a_q <= '0;
            hold_b_q <= '0;
        end else if (Capture) begin
            hold_a_q <= A;
            hold_b_q <= B;
        end
    end

    always_comb begin
        OutData = '0;
        if (State == StSendA) begin
            OutData = hold_a_q;
        end else if (State == StSendB) begin
            OutData = hold_b_q;
        end
    end

endmodule

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a wrapping range of register indices, reads them two
// at a time through the register file's A/B selects and streams each value out
// on a valid/ready interface.
//   Clock, Reset        : system clock, synchronous active-high reset
//   Start               : request a dump (sampled only when idle)
//   StartIdx, Count     : first index and register count (0 = none, >2**IDX_W clamps)
//   SelectA, SelectB    : read selects to the register file
//   A, B                : register file read data
//   OutValid, OutReady  : output beat handshake
//   OutData, OutIdx     : register value and its index
//   Busy                : sequencer not idle
//   Done                : one-cycle pulse at the end of a dump
//   OutParity           : XOR of OutData, present only with REG_DUMP_PARITY_EN
// Optional feature macro: REG_DUMP_PARITY_EN
// READ_LAT must be in 1..MAX_READ_LAT.
module reg_dump_reader
    import reg_dump_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned IDX_W    = IDX_W_DEF,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [IDX_W-1:0]  StartIdx,
    input  logic [IDX_W:0]    Count,
    output logic [IDX_W-1:0]  SelectA,
    output logic [IDX_W-1:0]  SelectB,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutData,
    output logic [IDX_W-1:0]  OutIdx,
    output logic              Busy,
    output logic              Done
`ifdef REG_DUMP_PARITY_EN
    ,
    output logic              OutParity
`endif
);

    localparam int unsigned CntW  = IDX_W + 1;
    localparam int unsigned WaitW = $clog2(MAX_READ_LAT);
    localparam logic [CntW-1:0]  RegCountC = CntW'(2 ** IDX_W);
    localparam logic [WaitW-1:0] LastWait  = WaitW'(READ_LAT - 1);

    state_e            state_q;
    logic [IDX_W-1:0]  cur_q;
    logic [CntW-1:0]   rem_q;
    logic [WaitW-1:0]  wait_q;
    logic [IDX_W-1:0]  sel_a_q;
    logic [IDX_W-1:0]  sel_b_q;

    logic              capture;
    logic [CntW-1:0]   rem_start;
    logic [CntW-1:0]   rem_after_b;
    logic [IDX_W-1:0]  cur_next_pair;

    assign capture       = (state_q == StSelect) && (wait_q == LastWait);
    assign rem_start     = (Count > RegCountC) ? RegCountC : Count;
    assign rem_after_b   = rem_q - CntW'(2);
    assign cur_next_pair = cur_q + IDX_W'(2);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StIdle;
            cur_q   <= '0;
            rem_q   <= '0;
            wait_q  <= '0;
            sel_a_q <= '0;
            sel_b_q <= '0;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (Start) begin
                        cur_q  <= StartIdx;
                        rem_q  <= rem_start;
                        wait_q <= '0;
                        if (rem_start == '0) begin
                            state_q <= StDone;
                            Done    <= 1'b1;
                        end else begin
                            state_q <= StSelect;
                            sel_a_q <= StartIdx;
                            sel_b_q <= StartIdx + IDX_W'(1);
                        end
                    end
                end
                StSelect: begin
                    if (capture) begin
                        state_q <= StSendA;
                    end else begin
                        wait_q <= wait_q + WaitW'(1);
                    end
                end
                StSendA: begin
                    if (OutReady) begin
                        // An odd count ends on the A half of the last pair.
                        if (rem_q == CntW'(1)) begin
                            state_q <= StDone;
                            Done    <= 1'b1;
                        end else begin
                            state_q <= StSendB;
                        end
                    end
                end
                StSendB: begin
                    if (OutReady) begin
                        rem_q <= rem_after_b;
                        cur_q <= cur_next_pair;
                        if (rem_after_b == '0) begin
                            state_q <= StDone;
                            Done    <= 1'b1;
                        end else begin
                            state_q <= StSelect;
                            wait_q  <= '0;
                            sel_a_q <= cur_next_pair;
                            sel_b_q <= cur_next_pair + IDX_W'(1);
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign SelectA  = sel_a_q;
    assign SelectB  = sel_b_q;
    assign Busy     = (state_q != StIdle);
    assign OutValid = (state_q == StSendA) || (state_q == StSendB);

    always_comb begin
        OutIdx = '0;
        if (state_q == StSendA) begin
            OutIdx = cur_q;
        end else if (state_q == StSendB) begin
            OutIdx = cur_q + IDX_W'(1);
        end
    end

    reg_dump_pair_buf #(
        .DATA_W (DATA_W)
    ) u_pair_buf (
        .Clock   (Clock),
        .Reset   (Reset),
        .Capture (capture),
        .State   (state_q),
        .A       (A),
        .B       (B),
        .OutData (OutData)
    );

`ifdef REG_DUMP_PARITY_EN
    assign OutParity = ^OutData;
`endif

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;

    typedef struct {
        logic [3:0]  idx;
        logic [15:0] data;
    } beat_t;

    typedef struct {
        logic [3:0] s;
        logic [4:0] c;
        int         beats;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        start3;
    logic [3:0]  start_idx;
    logic [4:0]  count;
    logic        out_ready;
    logic [15:0] regs [16];

    logic [3:0]  sel_a, sel_b, idx, sel_a3, sel_b3, idx3;
    logic [15:0] a, b, data, a3, b3, data3;
    logic        ov, busy, done, ov3, busy3, done3;
`ifdef REG_DUMP_PARITY_EN
    logic        par, par3;
`endif

    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int beat_cnt = 0;
    beat_t exp_q[$];
    logic [7:0] sel_q[$];

    assign a  = regs[sel_a];
    assign b  = regs[sel_b];
    assign a3 = regs[sel_a3];
    assign b3 = regs[sel_b3];

    reg_dump_reader #(.DATA_W(16), .IDX_W(4), .READ_LAT(1)) dut (
        .Clock(clk), .Reset(rst), .Start(start), .StartIdx(start_idx), .Count(count),
        .SelectA(sel_a), .SelectB(sel_b), .A(a), .B(b), .OutValid(ov), .OutReady(out_ready),
        .OutData(data), .OutIdx(idx), .Busy(busy), .Done(done)
`ifdef REG_DUMP_PARITY_EN
        , .OutParity(par)
`endif
    );

    reg_dump_reader #(.DATA_W(16), .IDX_W(4), .READ_LAT(3)) dut3 (
        .Clock(clk), .Reset(rst), .Start(start3), .StartIdx(start_idx), .Count(count),
        .SelectA(sel_a3), .SelectB(sel_b3), .A(a3), .B(b3), .OutValid(ov3),
        .OutReady(out_ready), .OutData(data3), .OutIdx(idx3), .Busy(busy3), .Done(done3)
`ifdef REG_DUMP_PARITY_EN
        , .OutParity(par3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard side: pop one expected beat per handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (ov && out_ready) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {28'd0, idx}, 32'hffff_ffff);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_idx", {28'd0, idx}, {28'd0, e.idx});
                    check("beat_data", {16'd0, data}, {16'd0, e.data});
                end
            end
            if (done) done_cnt++;
            if (busy && !ov && !done) sel_q.push_back({sel_a, sel_b});
        end
    end

    task automatic pulse_start(input logic [3:0] s, input logic [4:0] c);
        start_idx = s;
        count     = c;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
    endtask

    task automatic run_dump(input logic [3:0] s, input logic [4:0] c, input int exp_beats);
        int cyc, first_v, last_hs, done_cyc, busy_cyc, d0, b0;
        for (int i = 0; i < exp_beats; i++) begin
            beat_t e;
            e.idx  = s + 4'(i);
            e.data = regs[e.idx];
            exp_q.push_back(e);
        end
        d0 = done_cnt;
        b0 = beat_cnt;
        pulse_start(s, c);
        cyc = 0; first_v = -1; last_hs = -1; done_cyc = -1; busy_cyc = 0;
        while (done_cyc < 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cyc++;
            if (ov && first_v < 0) first_v = cyc;
            if (ov && out_ready) last_hs = cyc;
            if (done) done_cyc = cyc;
        end
        check("done_seen", {31'd0, done_cyc > 0}, 32'd1);
        if (exp_beats > 0) begin
            check("first_valid_latency", first_v, 2);
            check("done_after_last_beat", done_cyc, last_hs + 1);
        end else begin
            check("count0_done_cycle", done_cyc, 1);
            check("count0_busy_cycles", busy_cyc, 1);
            check("count0_no_valid", first_v, -1);
        end
        @(negedge clk);
        check("idle_after_done", {31'd0, busy}, 32'd0);
        check("done_pulses", done_cnt - d0, 1);
        check("beat_count", beat_cnt - b0, exp_beats);
        check("queue_drained", exp_q.size(), 0);
    endtask

    vec_t vecs[7];

    initial begin
        int d0;
        bit found;
        vecs[0] = '{s: 4'h2, c: 5'd4,  beats: 4};
        vecs[1] = '{s: 4'hE, c: 5'd3,  beats: 3};
        vecs[2] = '{s: 4'h0, c: 5'd0,  beats: 0};
        vecs[3] = '{s: 4'h0, c: 5'd20, beats: 16};
        vecs[4] = '{s: 4'h5, c: 5'd16, beats: 16};
        vecs[5] = '{s: 4'h9, c: 5'd1,  beats: 1};
        vecs[6] = '{s: 4'hF, c: 5'd2,  beats: 2};

        for (int i = 0; i < 16; i++) regs[i] = 16'h1000 + 16'(i);
        rst = 1'b1; start = 1'b0; start3 = 1'b0; start_idx = '0; count = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_selects", {24'd0, sel_a, sel_b}, 32'd0);
        check("reset_data_idx", {12'd0, data, idx}, 32'd0);
        check("reset_flags", {29'd0, ov, busy, done}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) run_dump(vecs[v].s, vecs[v].c, vecs[v].beats);

        // Wrapping range: select pairs must be E/F then 0/1.
        sel_q.delete();
        run_dump(4'hE, 5'd3, 3);
        check("sel_pair_count", sel_q.size(), 2);
        if (sel_q.size() == 2) begin
            check("sel_pair0", {24'd0, sel_q[0]}, 32'h00EF);
            check("sel_pair1", {24'd0, sel_q[1]}, 32'h0001);
        end

        // Back-pressure on the second beat; a Start meanwhile must be ignored.
        for (int i = 0; i < 4; i++) exp_q.push_back('{idx: 4'(2 + i), data: 16'h1002 + 16'(i)});
        d0 = done_cnt;
        pulse_start(4'h2, 5'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, ov}, 32'd1);
            check("stall_data", {16'd0, data}, 32'h1003);
            check("stall_idx", {28'd0, idx}, 32'd3);
            @(posedge clk); #1;
            if (k == 0) begin start_idx = 4'h9; start = 1'b1; end
            if (k == 1) start = 1'b0;
        end
        out_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        check("stall_done_seen", {31'd0, found}, 32'd1);
        repeat (3) @(negedge clk);
        check("stall_idle", {31'd0, busy}, 32'd0);
        check("stall_one_done", done_cnt - d0, 1);
        check("stall_queue", exp_q.size(), 0);
        @(posedge clk); #1;

        // Reset in SEND_B of a full dump aborts it.
        for (int i = 0; i < 16; i++) exp_q.push_back('{idx: 4'(i), data: 16'h1000 + 16'(i)});
        pulse_start(4'h0, 5'd16);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (ov && idx == 4'd5) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("reset_target_reached", {31'd0, found}, 32'd1);
        rst = 1'b1;
        exp_q.delete();
        d0 = done_cnt;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_flags", {29'd0, ov, busy, done}, 32'd0);
        check("abort_data_idx", {12'd0, data, idx}, 32'd0);
        check("abort_selects", {24'd0, sel_a, sel_b}, 32'd0);
        repeat (6) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        @(posedge clk); #1;
        run_dump(4'h3, 5'd5, 5);

        // READ_LAT=3 instance: SELECT holds three cycles.
        regs[1] = 16'h0007;
        start_idx = 4'h0; count = 5'd2; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rl3_select_wait", {30'd0, busy3, ov3}, 32'd2);
            check("rl3_select", {24'd0, sel_a3, sel_b3}, 32'h01);
        end
        @(negedge clk);
        check("rl3_beat0", {11'd0, ov3, idx3, data3}, {11'd0, 1'b1, 4'h0, 16'h1000});
`ifdef REG_DUMP_PARITY_EN
        check("rl3_parity0", {31'd0, par3}, 32'd1);
`endif
        @(negedge clk);
        check("rl3_beat1", {11'd0, ov3, idx3, data3}, {11'd0, 1'b1, 4'h1, 16'h0007});
`ifdef REG_DUMP_PARITY_EN
        check("rl3_parity1", {31'd0, par3}, 32'd1);
`endif
        @(negedge clk);
        check("rl3_done", {31'd0, done3}, 32'd1);
        regs[1] = 16'h1001;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
